// File: rtl/delay_loop_arbiter.sv
// delay_loop_arbiter: round-robin owner of one shared delay counter.
// The winner's delay is latched at grant; Done pulses one cycle after count==Dlat.
module delay_loop_arbiter #(
  parameter int NumReq       = 4,
  parameter int NumberOfBits = 27
) (
  input  logic                             Clock,
  input  logic                             MR,
  input  logic [NumReq-1:0]                Req,
  input  logic [NumReq*NumberOfBits-1:0]   DelayIn,
  output logic [NumReq-1:0]                Grant,
  output logic [NumReq-1:0]                Done,
  output logic                             Busy
);

  localparam int IW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic {
    IDLE,
    COUNT
  } state_e;

  state_e                  state_q, state_d;
  logic [NumReq-1:0]       grant_q, grant_d;
  logic [NumReq-1:0]       done_q, done_d;
  logic                    busy_q, busy_d;
  logic [NumberOfBits-1:0] count_q, count_d;
  logic [NumberOfBits-1:0] dlat_q, dlat_d;
  logic [IW-1:0]           ptr_q, ptr_d;

  logic [IW-1:0]           win;
  logic                    win_vld;
  logic                    abort;
  logic                    expire;

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] base,
    input int            k
  );
    int s;
    s = int'(base) + k;
    if (s >= NumReq) s = s - NumReq;
    return IW'(s);
  endfunction

  // Scan downward so the last hit is the nearest set bit at/after ptr_q.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      if (Req[wrap_add(ptr_q, k)]) begin
        win     = wrap_add(ptr_q, k);
        win_vld = 1'b1;
      end
    end
  end

  assign abort  = (grant_q & Req) == '0;
  assign expire = count_q == dlat_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = '0;
    busy_d  = busy_q;
    count_d = count_q;
    dlat_d  = dlat_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = COUNT;
          grant_d = NumReq'(1) << win;
          busy_d  = 1'b1;
          count_d = '0;
          dlat_d  = DelayIn[int'(win)*NumberOfBits +: NumberOfBits];
          ptr_d   = wrap_add(win, 1);
        end
      end
      COUNT: begin
        // An owner dropping Req wins over completion on the same edge.
        if (abort) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
        end else if (expire) begin
          state_d = IDLE;
          done_d  = grant_q;
          grant_d = '0;
          busy_d  = 1'b0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge MR) begin
    if (!MR) begin
      state_q <= IDLE;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      dlat_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      dlat_q  <= dlat_d;
      ptr_q   <= ptr_d;
    end
  end

  assign Grant = grant_q;
  assign Done  = done_q;
  assign Busy  = busy_q;

endmodule

// File: tb/tb_delay_loop_arbiter.sv
// Bench for delay_loop_arbiter: request-level model plus directed scenarios.
// A second narrow instance exercises an all-ones delay.
module tb_delay_loop_arbiter;
  localparam int NR  = 4;
  localparam int NB  = 27;
  localparam int NB2 = 4;

  logic             Clock = 1'b0;
  logic             MR    = 1'b0;
  logic [NR-1:0]    Req   = '0;
  logic [NR*NB-1:0] DelayIn = '0;
  logic [NR-1:0]    Grant, Done;
  logic             Busy;

  logic [NR-1:0]     Req2 = '0;
  logic [NR*NB2-1:0] DelayIn2 = '0;
  logic [NR-1:0]     Grant2, Done2;
  logic              Busy2;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 Clock = ~Clock;

  delay_loop_arbiter #(.NumReq(NR), .NumberOfBits(NB)) dut (
    .Clock(Clock), .MR(MR), .Req(Req), .DelayIn(DelayIn),
    .Grant(Grant), .Done(Done), .Busy(Busy)
  );

  delay_loop_arbiter #(.NumReq(NR), .NumberOfBits(NB2)) dut_w (
    .Clock(Clock), .MR(MR), .Req(Req2), .DelayIn(DelayIn2),
    .Grant(Grant2), .Done(Done2), .Busy(Busy2)
  );

  // Model: owner index (-1 = free), edges left before completion, pointer.
  int            m_owner = -1;
  int            m_left  = 0;
  int            m_ptr   = 0;
  logic [NR-1:0] m_grant = '0;
  logic [NR-1:0] m_done  = '0;
  logic          m_busy  = 1'b0;

  initial forever begin
    @(posedge Clock or negedge MR);
    if (!MR) begin
      m_owner = -1; m_left = 0; m_ptr = 0;
      m_grant = '0; m_done = '0; m_busy = 1'b0;
    end else if (m_owner < 0) begin
      m_done = '0;
      for (int k = 0; k < NR; k++)
        if (m_owner < 0 && Req[(m_ptr + k) % NR]) m_owner = (m_ptr + k) % NR;
      if (m_owner >= 0) begin
        m_left  = int'(DelayIn[m_owner*NB +: NB]);
        m_grant = NR'(1) << m_owner;
        m_busy  = 1'b1;
        m_ptr   = (m_owner + 1) % NR;
      end
    end else if (!Req[m_owner]) begin
      m_owner = -1; m_grant = '0; m_busy = 1'b0;
    end else if (m_left == 0) begin
      m_done  = m_grant;
      m_owner = -1; m_grant = '0; m_busy = 1'b0;
    end else begin
      m_left = m_left - 1;
    end
  end

  initial forever begin
    @(negedge Clock);
    if (chk_en && MR) begin
      vectors++;
      if ({Grant, Done, Busy} !== {m_grant, m_done, m_busy}) begin
        miscompares++;
        $display("FAIL model t=%0t got G=%b D=%b B=%b want G=%b D=%b B=%b",
                 $time, Grant, Done, Busy, m_grant, m_done, m_busy);
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic rst();
    @(negedge Clock);
    MR = 1'b0; Req = '0; Req2 = '0;
    @(negedge Clock);
    MR = 1'b1;
  endtask

  task automatic run_one(input int idx, input int dly, input int chg,
                         output int gc, output int dc);
    gc = 0; dc = 0;
    DelayIn[idx*NB +: NB] = NB'(dly);
    Req = NR'(1) << idx;
    repeat (40) begin
      @(negedge Clock);
      if (Grant[idx]) gc++;
      if (Done[idx]) begin dc++; Req = '0; end
      if (gc == 2 && chg >= 0) DelayIn[idx*NB +: NB] = NB'(chg);
    end
  endtask

  initial begin
    int gc, dc, n, cyc, j;
    int ord[5];
    logic [NR-1:0] pg, pd;

    rst();
    chk_en = 1'b1;
    check("reset_outputs", int'({Grant, Done, Busy}), 0);

    run_one(0, 3, -1, gc, dc);
    check("single_grant_cycles", gc, 4);
    check("single_done_cycles", dc, 1);

    // Narrow instance: all-ones delay must not wrap.
    DelayIn2[NB2-1:0] = 4'hF;
    Req2 = 4'b0001;
    gc = 0; dc = 0;
    repeat (30) begin
      @(negedge Clock);
      if (Grant2[0]) gc++;
      if (Done2[0]) begin dc++; Req2 = '0; end
    end
    check("wide_grant_cycles", gc, 16);
    check("wide_done_cycles", dc, 1);

    rst();
    for (int i = 0; i < NR; i++) DelayIn[i*NB +: NB] = NB'(1);
    Req = 4'hF;
    n = 0; pg = '0; pd = '0;
    for (int i = 0; i < 5; i++) ord[i] = -1;
    repeat (16) begin
      @(negedge Clock);
      if (pd != '0) check("rr_regrant_next_edge", int'(Grant != '0), 1);
      if (Grant != '0 && pg == '0 && n < 5) begin
        for (int i = 0; i < NR; i++) if (Grant[i]) ord[n] = i;
        n++;
      end
      pg = Grant; pd = Done;
    end
    Req = '0;
    check("rr_ord0", ord[0], 0);
    check("rr_ord1", ord[1], 1);
    check("rr_ord2", ord[2], 2);
    check("rr_ord3", ord[3], 3);
    check("rr_ord4", ord[4], 0);
    repeat (4) @(negedge Clock);

    rst();
    run_one(2, 0, -1, gc, dc);
    check("zero_grant_cycles", gc, 1);
    check("zero_done_cycles", dc, 1);
    run_one(1, 5, 1, gc, dc);
    check("latch_grant_cycles", gc, 6);
    check("latch_done_cycles", dc, 1);

    rst();
    DelayIn[1*NB +: NB] = NB'(10);
    DelayIn[3*NB +: NB] = NB'(2);
    Req = 4'b1010;
    repeat (3) @(negedge Clock);
    check("abort_owner", int'(Grant), 2);
    Req = 4'b1000;
    @(negedge Clock);
    check("abort_grant_clear", int'({Grant, Done}), 0);
    @(negedge Clock);
    check("abort_next_owner", int'(Grant), 8);
    repeat (6) begin
      @(negedge Clock);
      if (Done[3]) Req = '0;
    end

    rst();
    DelayIn[0*NB +: NB] = NB'(20);
    Req = 4'b0001;
    repeat (4) @(negedge Clock);
    check("midrst_busy_before", int'(Busy), 1);
    #2 MR = 1'b0;
    #1 check("midrst_async_clear", int'({Grant, Done, Busy}), 0);
    @(negedge Clock);
    MR = 1'b1;
    DelayIn[0*NB +: NB] = NB'(1);
    DelayIn[3*NB +: NB] = NB'(1);
    Req = 4'b1001;
    @(negedge Clock);
    check("midrst_first_grant", int'(Grant), 1);
    repeat (12) begin
      @(negedge Clock);
      Req = Req & ~Done;
    end

    cyc = 0;
    repeat (3000) begin
      @(negedge Clock);
      cyc++;
      for (int i = 0; i < NR; i++) begin
        if (!Req[i]) begin
          if ($urandom_range(3) == 0) begin
            DelayIn[i*NB +: NB] = NB'($urandom_range(6));
            Req[i] = 1'b1;
          end
        end else if (Done[i]) begin
          if ($urandom_range(1) == 0) Req[i] = 1'b0;
        end else if ($urandom_range(29) == 0) begin
          Req[i] = 1'b0;
        end
      end
      if ($urandom_range(9) == 0) begin
        j = int'($urandom_range(NR - 1));
        DelayIn[j*NB +: NB] = NB'($urandom_range(6));
      end
      if (cyc == 1500) begin
        #2 MR = 1'b0;
        #1 check("rand_async_clear", int'({Grant, Done, Busy}), 0);
        @(negedge Clock);
        MR = 1'b1;
      end
    end
    Req = '0;
    repeat (3) @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/delay_loop_arbiter.md
Name: delay_loop_arbiter

Overview:
- Shares one programmable delay counter among NumReq requesters.
- Each requester asks for a delay of D clock cycles. The block grants the counter round-robin, runs the count, then pulses that requester's Done.
- Sits between the FSMs that need timed waits and the single shared delay counter, replacing per-FSM dividers.

Parameters:
NumReq, 4, number of requesters (2..8)
NumberOfBits, 27, width of each delay value and of the internal counter

Ports:
Clock  input  1  system clock; all state updates on rising edge
MR  input  1  master reset, asynchronous, active-low (0 = reset)
Req  input  NumReq  per-requester level request; hold high until Done or to abort
DelayIn  input  NumReq*NumberOfBits  packed delay values; requester i uses bits [i*NumberOfBits +: NumberOfBits]
Grant  output  NumReq  one-hot owner of the counter; all zero when idle
Done  output  NumReq  one-cycle completion pulse to the owner
Busy  output  1  high while the counter is in use (state COUNT)

Behaviour:
- Reset (MR=0, asynchronous):
  - state=IDLE; Grant=0, Done=0, Busy=0; count=0; latched delay=0.
  - Priority pointer is set so requester 0 has highest priority first.
- States: IDLE, COUNT. All outputs are registered.
- IDLE:
  - Done is cleared every edge; a Done pulse is therefore exactly one cycle.
  - If Req != 0 at a rising edge, pick winner w: the first set Req bit searching upward (with wrap) from pointer.
  - On that same edge: Grant=one-hot(w); Dlat=DelayIn[w]; count=0; Busy=1; pointer=w+1 mod NumReq; state=COUNT.
  - If Req == 0, remain in IDLE.
- COUNT, evaluated on each edge in this order:
  - Abort: Req[w]=0 gives state=IDLE, Grant=0, Busy=0, and no Done.
  - Completion: otherwise, if count==Dlat, then Done[w]=1, Grant=0, Busy=0, state=IDLE.
  - Otherwise count increments by 1.
- Latency: if the grant edge is E0, Done is high in the cycle following edge E(Dlat+1).
  - Dlat=0 gives Done one cycle after grant.
  - The counter holds values 0..Dlat, i.e. Dlat+1 cycles of Grant.
- Delay latching: Dlat is captured only at grant. Later DelayIn changes and other Req changes are ignored until IDLE.
- Re-arbitration: the IDLE cycle that carries Done also arbitrates; the earliest next grant is the edge ending that cycle.
  - A requester that keeps Req high after Done is re-granted only if no other requester is pending (rotated pointer).
- Widths:
  - count never exceeds Dlat.
  - Dlat = all-ones (2^NumberOfBits-1) is legal and must not wrap before completion.
- Simultaneous events: completion and abort on the same edge resolve as abort (no Done).
- Reset mid-COUNT: outputs clear immediately (asynchronous), with no Done pulse.
- Invariants:
  - Grant is at most one-hot.
  - Done is at most one-hot and only for the last owner.
  - Done and Grant are never both set for the same bit.

Test Plan:
- Single request: Req=0001, DelayIn[0]=3 → Grant=0001 for 4 cycles, Done=0001 for exactly 1 cycle, Busy falls with Grant.
- Round-robin: Req=1111 held, all delays 1 → grant order 0,1,2,3,0, each Done one cycle; the next Grant is asserted one edge after each Done.
- Zero delay plus latching: DelayIn[2]=0, Req=0100 → Done[2] one cycle after grant. Also: DelayIn[1]=5 at grant, changed to 1 mid-count → Done still after 6 Grant cycles.
- Abort: Req[1] dropped at count=2 of Dlat=10 → Grant=0 next edge, no Done. Pending Req[3] is granted on the following edge.
- Reset mid-operation: MR pulled low between clock edges during COUNT → Grant, Done, Busy go 0 without waiting for a clock. After release, Req=1000 and Req=0001 together → requester 0 is granted first.
- Wide delay: NumberOfBits=4, Dlat=15 → Done after exactly 16 Grant cycles, with no wrap to 0.
